// File: rtl/charram_dram_ctrl.sv
// charram_dram_ctrl: single-plane 4416 character-RAM sequencer with a
// video-priority two-port arbiter and a bounded CPU starvation guard.
module charram_dram_ctrl #(
  parameter int unsigned MAX_CPU_WAIT = 2
) (
  input  logic        i_MCLK,
  input  logic        i_RST_n,
  input  logic        i_VID_REQ,
  input  logic [13:0] i_VID_ADDR,
  output logic [3:0]  o_VID_DOUT,
  output logic        o_VID_VALID,
  output logic        o_VID_OVF,
  input  logic        i_CPU_REQ,
  input  logic        i_CPU_WE,
  input  logic [13:0] i_CPU_ADDR,
  input  logic [3:0]  i_CPU_DIN,
  output logic [3:0]  o_CPU_DOUT,
  output logic        o_CPU_ACK,
  output logic        o_CPU_BUSY,
  output logic [7:0]  o_DRAM_ADDR,
  output logic [3:0]  o_DRAM_DIN,
  input  logic [3:0]  i_DRAM_DOUT,
  output logic        o_DRAM_RAS_n,
  output logic        o_DRAM_CAS_n,
  output logic        o_DRAM_RD_n,
  output logic        o_DRAM_WR_n
);

  localparam logic [2:0] WAIT_LIMIT = 3'(MAX_CPU_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_COL,
    S_ACC,
    S_PRE
  } state_t;

  state_t      state, state_nxt;

  // Pending request slots (depth 1 each)
  logic        vid_full;
  logic [13:0] vid_addr;
  logic        cpu_full;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [3:0]  cpu_din;
  logic [2:0]  cpu_wait;

  // Access in flight, latched at the grant edge
  logic        act_vid;
  logic        act_we;
  logic [13:0] act_addr;
  logic [3:0]  act_din;

  logic        arb;
  logic        grant_vid;
  logic        grant_cpu;
  logic [13:0] sel_addr;
  logic        ras_nxt, cas_nxt, rd_nxt, wr_nxt;
  logic [7:0]  addr_nxt;
  logic [3:0]  din_nxt;

  // Arbitration, next state and next values of the registered DRAM pins.
  // Pins are computed from the next state so they change on the same edge
  // the state does; the ROW address comes straight from the winning slot.
  always_comb begin
    state_nxt = state;
    arb       = (state == S_IDLE) || (state == S_PRE);
    grant_cpu = arb && cpu_full && (!vid_full || (cpu_wait >= WAIT_LIMIT));
    grant_vid = arb && vid_full && !grant_cpu;
    sel_addr  = grant_vid ? vid_addr : cpu_addr;

    case (state)
      S_IDLE:  if (grant_vid || grant_cpu) state_nxt = S_ROW;
      S_ROW:   state_nxt = S_COL;
      S_COL:   state_nxt = S_ACC;
      S_ACC:   state_nxt = S_PRE;
      S_PRE:   state_nxt = (grant_vid || grant_cpu) ? S_ROW : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    ras_nxt  = 1'b1;
    cas_nxt  = 1'b1;
    rd_nxt   = 1'b1;
    wr_nxt   = 1'b1;
    addr_nxt = o_DRAM_ADDR;
    din_nxt  = o_DRAM_DIN;
    case (state_nxt)
      S_ROW: begin
        ras_nxt  = 1'b0;
        addr_nxt = sel_addr[7:0];
      end
      S_COL: begin
        ras_nxt  = 1'b0;
        cas_nxt  = 1'b0;
        addr_nxt = {1'b0, act_addr[13:8], 1'b0};
      end
      S_ACC: begin
        ras_nxt  = 1'b0;
        cas_nxt  = 1'b0;
        addr_nxt = {1'b0, act_addr[13:8], 1'b0};
        rd_nxt   = act_we;
        wr_nxt   = !act_we;
        din_nxt  = act_din;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge i_MCLK) begin
    if (!i_RST_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Request slots, starvation counter and active-access latch
  always_ff @(posedge i_MCLK) begin
    if (!i_RST_n) begin
      vid_full  <= 1'b0;
      vid_addr  <= '0;
      cpu_full  <= 1'b0;
      cpu_we    <= 1'b0;
      cpu_addr  <= '0;
      cpu_din   <= '0;
      cpu_wait  <= '0;
      o_VID_OVF <= 1'b0;
      act_vid   <= 1'b0;
      act_we    <= 1'b0;
      act_addr  <= '0;
      act_din   <= '0;
    end else begin
      // Grant clears a slot; a strobe on the same edge reloads it
      if (grant_vid) vid_full <= 1'b0;
      if (i_VID_REQ) begin
        vid_full <= 1'b1;
        vid_addr <= i_VID_ADDR;
        if (vid_full && !grant_vid) o_VID_OVF <= 1'b1;
      end

      if (grant_cpu) cpu_full <= 1'b0;
      if (i_CPU_REQ && (!cpu_full || grant_cpu)) begin
        cpu_full <= 1'b1;
        cpu_we   <= i_CPU_WE;
        cpu_addr <= i_CPU_ADDR;
        cpu_din  <= i_CPU_DIN;
      end

      if (grant_cpu)
        cpu_wait <= '0;
      else if (grant_vid && cpu_full && (cpu_wait != 3'd7))
        cpu_wait <= cpu_wait + 3'd1;

      if (grant_vid || grant_cpu) begin
        act_vid  <= grant_vid;
        act_we   <= grant_cpu && cpu_we;
        act_addr <= sel_addr;
        act_din  <= grant_cpu ? cpu_din : '0;
      end
    end
  end

  // Registered DRAM pins and requester responses (captured leaving PRE)
  always_ff @(posedge i_MCLK) begin
    if (!i_RST_n) begin
      o_DRAM_RAS_n <= 1'b1;
      o_DRAM_CAS_n <= 1'b1;
      o_DRAM_RD_n  <= 1'b1;
      o_DRAM_WR_n  <= 1'b1;
      o_DRAM_ADDR  <= '0;
      o_DRAM_DIN   <= '0;
      o_VID_VALID  <= 1'b0;
      o_VID_DOUT   <= '0;
      o_CPU_ACK    <= 1'b0;
      o_CPU_DOUT   <= '0;
    end else begin
      o_DRAM_RAS_n <= ras_nxt;
      o_DRAM_CAS_n <= cas_nxt;
      o_DRAM_RD_n  <= rd_nxt;
      o_DRAM_WR_n  <= wr_nxt;
      o_DRAM_ADDR  <= addr_nxt;
      o_DRAM_DIN   <= din_nxt;
      o_VID_VALID  <= (state == S_PRE) && act_vid;
      o_CPU_ACK    <= (state == S_PRE) && !act_vid;
      if ((state == S_PRE) && act_vid)            o_VID_DOUT <= i_DRAM_DOUT;
      if ((state == S_PRE) && !act_vid && !act_we) o_CPU_DOUT <= i_DRAM_DOUT;
    end
  end

  assign o_CPU_BUSY = cpu_full;

endmodule
